// File: rtl/mode_pkg.sv
// Shared stage codes, skip-mask bit positions and the stage ordering helper
// for the compute-run sequencer.
package mode_pkg;

   // Stage codes double as the externally visible mode_num value.
   typedef enum logic [2:0] {
      ST_IDLE = 3'b000,
      ST_MEM  = 3'b001,
      ST_PE   = 3'b010,
      ST_SA3  = 3'b011,
      ST_SA2  = 3'b100,
      ST_DISP = 3'b101,
      ST_ERR  = 3'b111
   } mode_t;

   localparam int SKIP_PE  = 0;
   localparam int SKIP_SA3 = 1;
   localparam int SKIP_SA2 = 2;

   localparam int TIMEOUT_DEFAULT = 1024;

   // Next stage after a compute stage completes; MEM and DISP are never skipped.
   function automatic mode_t next_stage(input mode_t cur, input logic [2:0] skip);
      mode_t nxt;
      nxt = ST_DISP;
      case (cur)
         ST_MEM: begin
            if (!skip[SKIP_PE])       nxt = ST_PE;
            else if (!skip[SKIP_SA3]) nxt = ST_SA3;
            else if (!skip[SKIP_SA2]) nxt = ST_SA2;
         end
         ST_PE: begin
            if (!skip[SKIP_SA3])      nxt = ST_SA3;
            else if (!skip[SKIP_SA2]) nxt = ST_SA2;
         end
         ST_SA3: begin
            if (!skip[SKIP_SA2])      nxt = ST_SA2;
         end
         default: nxt = ST_DISP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Control/status bundle between the board-level controls, the stage blocks
// and the mode sequencer. The sequencer uses the slave view.
interface mode_sequencer_if #(
   parameter int CNT_W = 16
) ();
   logic             start;
   logic             abort;
   logic             clear;
   logic [2:0]       skip_mask;
   logic             mem_done;
   logic             pe_done;
   logic             sa3_done;
   logic             sa2_done;
   logic [2:0]       mode_num;
   logic             enable_memory;
   logic             enable_singlePE;
   logic             enable_SA3x3;
   logic             enable_SA2x2;
   logic             enable_display;
   logic             busy;
   logic             run_done;
   logic             error;
   logic [2:0]       err_stage;
   logic [CNT_W-1:0] stage_cycles;

   modport master (
      output start, abort, clear, skip_mask,
      output mem_done, pe_done, sa3_done, sa2_done,
      input  mode_num, enable_memory, enable_singlePE, enable_SA3x3,
      input  enable_SA2x2, enable_display, busy, run_done, error,
      input  err_stage, stage_cycles
   );

   modport slave (
      input  start, abort, clear, skip_mask,
      input  mem_done, pe_done, sa3_done, sa2_done,
      output mode_num, enable_memory, enable_singlePE, enable_SA3x3,
      output enable_SA2x2, enable_display, busy, run_done, error,
      output err_stage, stage_cycles
   );
endinterface

// File: rtl/stage_watchdog.sv
// Per-stage cycle counter: cleared whenever the sequencer changes state,
// flags the terminal count (compute timeout or display length) and captures
// the active-cycle count of a stage as it completes.
module stage_watchdog #(
   parameter int TIMEOUT     = 1024,
   parameter int DISP_CYCLES = 256,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             clr,
   input  logic             disp_sel,
   input  logic             capture,
   output logic             tc,
   output logic [CNT_W-1:0] captured
);
   localparam logic [CNT_W-1:0] LIM_TMO  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LIM_DISP = CNT_W'(DISP_CYCLES - 1);

   // cnt holds (active cycles so far - 1) during a stage, 0 outside stages.
   logic [CNT_W-1:0] cnt;

   assign tc = (cnt == (disp_sel ? LIM_DISP : LIM_TMO));

   // Count active cycles; restart on every state change; capture on completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         captured <= '0;
      end else begin
         if (clr || !run) cnt <= '0;
         else             cnt <= cnt + CNT_W'(1);
         if (capture)     captured <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/mode_sequencer.sv
// Sequences one compute run MEM -> PE -> SA3 -> SA2 -> DISP with optional
// skipping, per-stage watchdog, abort and an error trap.
//
// state | meaning
// IDLE  | waiting for start
// MEM   | memory load active, waits mem_done
// PE    | single PE active, waits pe_done
// SA3   | 3x3 systolic array active, waits sa3_done
// SA2   | 2x2 systolic array active, waits sa2_done
// DISP  | display held for DISP_CYCLES, then run_done
// ERR   | compute stage timed out, waits clear
module mode_sequencer
   import mode_pkg::*;
#(
   parameter int TIMEOUT     = TIMEOUT_DEFAULT,
   parameter int DISP_CYCLES = 256,
   parameter int CNT_W       = 16
) (
   input  logic           clk,
   input  logic           rst,
   mode_sequencer_if.slave bus
);
   mode_t      state;
   mode_t      state_nxt;
   logic [2:0] skip_q;
   logic [4:0] en_q;
   logic       busy_q;
   logic       run_done_q;
   logic       error_q;
   logic [2:0] err_stage_q;

   logic       is_compute;
   logic       own_done;
   logic       abort_hit;
   logic       start_acc;
   logic       clear_acc;
   logic       done_acc;
   logic       tmo;
   logic       disp_end;
   logic       leave;
   logic       capture;
   logic       wd_tc;
   logic [CNT_W-1:0] wd_captured;

   stage_watchdog #(
      .TIMEOUT     (TIMEOUT),
      .DISP_CYCLES (DISP_CYCLES),
      .CNT_W       (CNT_W)
   ) u_wd (
      .clk      (clk),
      .rst      (rst),
      .run      (is_compute || (state == ST_DISP)),
      .clr      (leave),
      .disp_sel (state == ST_DISP),
      .capture  (capture),
      .tc       (wd_tc),
      .captured (wd_captured)
   );

   // Transition events and next state; abort outranks done, timeout and clear,
   // and a stage's own done outranks its timeout.
   always_comb begin
      is_compute = (state == ST_MEM) || (state == ST_PE) ||
                   (state == ST_SA3) || (state == ST_SA2);
      case (state)
         ST_MEM:  own_done = bus.mem_done;
         ST_PE:   own_done = bus.pe_done;
         ST_SA3:  own_done = bus.sa3_done;
         ST_SA2:  own_done = bus.sa2_done;
         default: own_done = 1'b0;
      endcase
      abort_hit = bus.abort && (state != ST_IDLE);
      start_acc = (state == ST_IDLE) && bus.start && !bus.abort;
      clear_acc = (state == ST_ERR) && bus.clear;
      done_acc  = is_compute && own_done;
      tmo       = is_compute && wd_tc && !own_done;
      disp_end  = (state == ST_DISP) && wd_tc;

      state_nxt = state;
      if (abort_hit)      state_nxt = ST_IDLE;
      else if (start_acc) state_nxt = ST_MEM;
      else if (done_acc)  state_nxt = next_stage(state, skip_q);
      else if (tmo)       state_nxt = ST_ERR;
      else if (disp_end)  state_nxt = ST_IDLE;
      else if (clear_acc) state_nxt = ST_IDLE;

      leave   = (state_nxt != state);
      capture = !abort_hit && (done_acc || disp_end);
   end

   // State register and registered outputs, all decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         skip_q      <= 3'b000;
         en_q        <= 5'b00000;
         busy_q      <= 1'b0;
         run_done_q  <= 1'b0;
         error_q     <= 1'b0;
         err_stage_q <= 3'b000;
      end else begin
         state      <= state_nxt;
         en_q       <= {state_nxt == ST_DISP, state_nxt == ST_SA2, state_nxt == ST_SA3,
                        state_nxt == ST_PE,   state_nxt == ST_MEM};
         busy_q     <= (state_nxt != ST_IDLE) && (state_nxt != ST_ERR);
         run_done_q <= disp_end && !abort_hit;
         error_q    <= (state_nxt == ST_ERR);
         if (start_acc) begin
            skip_q      <= bus.skip_mask;
            err_stage_q <= 3'b000;
         end else if (tmo && !abort_hit) begin
            err_stage_q <= state;
         end
      end
   end

   assign bus.mode_num        = state;
   assign bus.enable_memory   = en_q[0];
   assign bus.enable_singlePE = en_q[1];
   assign bus.enable_SA3x3    = en_q[2];
   assign bus.enable_SA2x2    = en_q[3];
   assign bus.enable_display  = en_q[4];
   assign bus.busy            = busy_q;
   assign bus.run_done        = run_done_q;
   assign bus.error           = error_q;
   assign bus.err_stage       = err_stage_q;
   assign bus.stage_cycles    = wd_captured;
endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed vector table, corner-case sequences and
// randomized traffic against a run-plan reference model.
module tb_mode_sequencer;
   localparam int TMO  = 16;
   localparam int DISP = 4;
   localparam int CW   = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mode_sequencer_if #(.CNT_W(CW)) sif ();

   mode_sequencer #(.TIMEOUT(TMO), .DISP_CYCLES(DISP), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   int checks = 0;
   int errors = 0;

   // reference model: current stage, remaining planned stages, counters
   int m_mode, m_cnt, m_sc, m_err_stage, m_rd;
   int plan[$];

   // observations of the DUT
   int       seen[$];
   logic [2:0] prev_mode;
   int       rd_count, pe_cycles;
   logic     pe_seen, sa2_seen, err_seen;

   typedef struct {
      logic       start, abort, clear;
      logic [2:0] skip;
      logic [3:0] done;    // {sa2, sa3, pe, mem}
      logic [2:0] mode;
      logic       rd;
      logic [15:0] sc;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [4:0] onehot(input int m);
      if (m >= 1 && m <= 5) return 5'(1 << (m - 1));
      return 5'b0;
   endfunction

   function automatic logic [31:0] act_vec();
      return {2'b0, sif.mode_num,
              sif.enable_display, sif.enable_SA2x2, sif.enable_SA3x3,
              sif.enable_singlePE, sif.enable_memory,
              sif.busy, sif.run_done, sif.error, sif.err_stage, sif.stage_cycles};
   endfunction

   function automatic logic [31:0] exp_vec();
      return {2'b0, 3'(m_mode), onehot(m_mode),
              (m_mode != 0 && m_mode != 7), 1'(m_rd), (m_mode == 7),
              3'(m_err_stage), 16'(m_sc)};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_sc = 0; m_err_stage = 0; m_rd = 0;
      plan.delete();
   endtask

   // One clock of the reference model, using the inputs currently applied.
   task automatic model_step();
      logic [3:0] dn;
      dn = {sif.sa2_done, sif.sa3_done, sif.pe_done, sif.mem_done};
      m_rd = 0;
      if (m_mode == 0) begin
         if (sif.start && !sif.abort) begin
            plan.delete();
            plan.push_back(1);
            for (int s = 0; s < 3; s++) if (!sif.skip_mask[s]) plan.push_back(s + 2);
            plan.push_back(5);
            m_mode = plan.pop_front();
            m_cnt = 0;
            m_err_stage = 0;
         end
      end else if (sif.abort) begin
         m_mode = 0; m_cnt = 0;
      end else if (m_mode == 7) begin
         if (sif.clear) m_mode = 0;
      end else begin
         m_cnt++;
         if (m_mode == 5) begin
            if (m_cnt == DISP) begin m_mode = 0; m_rd = 1; m_sc = DISP; end
         end else if (dn[m_mode - 1]) begin
            m_sc = m_cnt; m_mode = plan.pop_front(); m_cnt = 0;
         end else if (m_cnt == TMO) begin
            m_err_stage = m_mode; m_mode = 7; m_cnt = 0;
         end
      end
   endtask

   task automatic obs_clear();
      seen.delete();
      prev_mode = sif.mode_num;
      rd_count = 0; pe_cycles = 0;
      pe_seen = 0; sa2_seen = 0; err_seen = 0;
   endtask

   // Step model, clock DUT, compare every output against the model.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("cycle_outputs", act_vec(), exp_vec());
      if (sif.mode_num != prev_mode) seen.push_back(int'(sif.mode_num));
      prev_mode = sif.mode_num;
      rd_count += int'(sif.run_done);
      if (sif.mode_num == 3'd2) pe_cycles++;
      pe_seen  |= sif.enable_singlePE;
      sa2_seen |= sif.enable_SA2x2;
      err_seen |= sif.error;
   endtask

   function automatic logic [31:0] seen_code();
      logic [31:0] v = 0;
      foreach (seen[i]) v = (v << 4) | 32'(seen[i]);
      return v;
   endfunction

   task automatic clear_inputs();
      sif.start = 0; sif.abort = 0; sif.clear = 0;
      sif.mem_done = 0; sif.pe_done = 0; sif.sa3_done = 0; sif.sa2_done = 0;
   endtask

   task automatic start_run(input logic [2:0] skip);
      sif.skip_mask = skip;
      sif.start = 1;
      cycle();
      sif.start = 0;
   endtask

   // Drive each stage's done on the given active cycle (0 = never) until the
   // model reaches stop_mode, IDLE or ERR.
   task automatic auto_run(input int dm, input int dp, input int d3, input int d2,
                           input int stop_mode, input int limit);
      int n = 0;
      while (m_mode != 0 && m_mode != 7 && m_mode != stop_mode && n < limit) begin
         sif.mem_done = (m_mode == 1) && (m_cnt + 1 == dm);
         sif.pe_done  = (m_mode == 2) && (m_cnt + 1 == dp);
         sif.sa3_done = (m_mode == 3) && (m_cnt + 1 == d3);
         sif.sa2_done = (m_mode == 4) && (m_cnt + 1 == d2);
         cycle();
         n++;
      end
      clear_inputs();
      chk("run_bound", 32'(n < limit), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      clear_inputs();
      sif.skip_mask = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_values", act_vec(), 32'd0);
      rst = 1;
      obs_clear();

      // directed table: abort beats start, skip 111, ignored dones/start
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd7, 4'b0000, 3'd1, 1'b0, 16'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd7, 4'b0001, 3'd5, 1'b0, 16'd1};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'b0010, 3'd5, 1'b0, 16'd1};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd5, 1'b0, 16'd1};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd5, 1'b0, 16'd1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b1, 16'd4};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd0, 4'b0000, 3'd0, 1'b0, 16'd4};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd7, 4'b0000, 3'd1, 1'b0, 16'd4};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'b0010, 3'd1, 1'b0, 16'd4};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 4'b0001, 3'd0, 1'b0, 16'd4};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'b0001, 3'd0, 1'b0, 16'd4};
      for (int i = 0; i < 12; i++) begin
         sif.start = tbl[i].start; sif.abort = tbl[i].abort; sif.clear = tbl[i].clear;
         sif.skip_mask = tbl[i].skip;
         {sif.sa2_done, sif.sa3_done, sif.pe_done, sif.mem_done} = tbl[i].done;
         cycle();
         chk("tbl_mode", 32'(sif.mode_num), 32'(tbl[i].mode));
         chk("tbl_enables", 32'({sif.enable_display, sif.enable_SA2x2, sif.enable_SA3x3,
                                 sif.enable_singlePE, sif.enable_memory}), 32'(onehot(int'(tbl[i].mode))));
         chk("tbl_run_done", 32'(sif.run_done), 32'(tbl[i].rd));
         chk("tbl_stage_cycles", 32'(sif.stage_cycles), 32'(tbl[i].sc));
      end
      clear_inputs();

      // nominal run, done 3 cycles after each enable rises
      obs_clear();
      start_run(3'b000);
      auto_run(4, 4, 4, 4, 8, 200);
      chk("nominal_sequence", seen_code(), 32'h123450);
      chk("nominal_run_done_count", 32'(rd_count), 32'd1);
      chk("nominal_disp_cycles", 32'(sif.stage_cycles), 32'd4);

      // skip PE and SA2
      obs_clear();
      start_run(3'b101);
      auto_run(2, 0, 3, 0, 8, 200);
      chk("skip101_sequence", seen_code(), 32'h1350);
      chk("skip101_pe_never", 32'(pe_seen), 32'd0);
      chk("skip101_sa2_never", 32'(sa2_seen), 32'd0);

      // PE timeout, then clear
      obs_clear();
      start_run(3'b000);
      auto_run(4, 0, 4, 4, 8, 200);
      chk("tmo_error", 32'(sif.error), 32'd1);
      chk("tmo_err_stage", 32'(sif.err_stage), 32'd2);
      chk("tmo_mode", 32'(sif.mode_num), 32'd7);
      chk("tmo_pe_cycles", 32'(pe_cycles), 32'd16);
      chk("tmo_stage_cycles", 32'(sif.stage_cycles), 32'd4);
      repeat (2) cycle();
      sif.clear = 1;
      cycle();
      sif.clear = 0;
      chk("clear_mode", 32'(sif.mode_num), 32'd0);
      chk("clear_err_stage_held", 32'(sif.err_stage), 32'd2);
      chk("clear_stage_cycles", 32'(sif.stage_cycles), 32'd4);
      start_run(3'b111);
      chk("start_clears_err_stage", 32'(sif.err_stage), 32'd0);
      auto_run(2, 0, 0, 0, 8, 200);

      // done on the terminal watchdog cycle wins
      obs_clear();
      start_run(3'b000);
      auto_run(4, 4, 4, TMO, 5, 200);
      chk("done_at_tmo_stage_cycles", 32'(sif.stage_cycles), 32'(TMO));
      auto_run(0, 0, 0, 0, 8, 200);
      chk("done_at_tmo_sequence", seen_code(), 32'h123450);
      chk("done_at_tmo_no_err", 32'(err_seen), 32'd0);

      // abort with sa3_done in SA3
      obs_clear();
      start_run(3'b000);
      auto_run(4, 4, 0, 0, 3, 200);
      cycle();
      sif.abort = 1; sif.sa3_done = 1;
      cycle();
      clear_inputs();
      chk("abort_mode", 32'(sif.mode_num), 32'd0);
      chk("abort_enables", 32'({sif.enable_display, sif.enable_SA2x2, sif.enable_SA3x3,
                                sif.enable_singlePE, sif.enable_memory}), 32'd0);
      chk("abort_stage_cycles", 32'(sif.stage_cycles), 32'd4);
      repeat (3) cycle();
      chk("abort_no_run_done", 32'(rd_count), 32'd0);
      start_run(3'b000);
      chk("abort_restart_mem", 32'(sif.mode_num), 32'd1);
      auto_run(1, 2, 3, 5, 8, 200);

      // asynchronous reset mid-DISP, between edges
      start_run(3'b110);
      auto_run(3, 2, 0, 0, 5, 200);
      cycle();
      #3;
      rst = 0;
      #1;
      model_reset();
      chk("async_reset_outputs", act_vec(), 32'd0);
      @(posedge clk);
      #1;
      chk("async_reset_held", act_vec(), 32'd0);
      rst = 1;
      obs_clear();
      repeat (2) cycle();
      chk("no_run_done_after_reset", 32'(rd_count), 32'd0);
      start_run(3'b010);
      auto_run(2, 3, 0, 6, 8, 200);
      chk("post_reset_sequence", seen_code(), 32'h12450);
      chk("post_reset_run_done", 32'(rd_count), 32'd1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         sif.start     = ($urandom_range(0, 3) == 0);
         sif.abort     = ($urandom_range(0, 49) == 0);
         sif.clear     = ($urandom_range(0, 3) == 0);
         sif.skip_mask = 3'($urandom_range(0, 7));
         sif.mem_done  = ($urandom_range(0, 7) == 0);
         sif.pe_done   = ($urandom_range(0, 7) == 0);
         sif.sa3_done  = ($urandom_range(0, 7) == 0);
         sif.sa2_done  = ($urandom_range(0, 7) == 0);
         cycle();
      end
      clear_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
